wb_fifo_device: RTL and testbench

- Wishbone classic device-side endpoint. Pin set matches the device modport of the `wishbone_classic` interface: no address bus.
- Backed by an internal FIFO. Writes push `dat_i`; reads pop onto `dat_o`.
- Terminates each cycle with exactly one of ack/err/rty.
- Used as a data sink/source behind a Wishbone controller, e.g. a byte stream endpoint.

---
 rtl/wb_fifo_device.sv | 133 +++++++++++++
 tb/tb_wb_fifo_device.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fifo_device.sv
// wb_fifo_device
//   Wishbone classic device endpoint backed by a DEPTH-entry FIFO.
//   A write cycle pushes dat_i. A read cycle pops the head word into dat_o.
//   Every accepted cycle ends with a single registered response pulse
//   (ack, err or rty), so the bus sees one wait state per transfer.
//
//   Build option:
//     WB_FIFO_RTY_EN  defined   -> overflow/underflow terminate with rty_o
//                     undefined -> overflow/underflow terminate with err_o
module wb_fifo_device #(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cyc_i,
    input  logic                         stb_i,
    input  logic                         we_i,
    input  logic [DAT_WIDTH-1:0]         dat_i,
    output logic [DAT_WIDTH-1:0]         dat_o,
    output logic                         ack_o,
    output logic                         err_o,
    output logic                         rty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // What the current accept edge will do to the FIFO and the response.
    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REFUSE
    } op_e;

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic                 full_q;
    logic                 empty_q;
    logic                 ack_q;
    logic                 refuse_q;
    logic                 busy;
    logic                 accept;
    op_e                  op;

    // A response in flight blocks acceptance, which forces the response to
    // drop after one cycle and gives the two-clock transfer rhythm.
    assign busy   = ack_q | refuse_q;
    assign accept = cyc_i & stb_i & ~busy;

    // Classify the accepted request; pointer wrap is free because DEPTH
    // is a power of two.
    // NOTE: always_comb assigns every output a default first so no path
    // leaves op unassigned, which would otherwise infer a latch.
    always_comb begin
        op = OP_IDLE;
        if (accept) begin
            if (we_i) begin
                op = full_q ? OP_REFUSE : OP_PUSH;
            end else begin
                op = empty_q ? OP_REFUSE : OP_POP;
            end
        end
    end

    // FIFO storage: written only on a successful push.
    // NOTE: the storage array has no reset; its contents are meaningless
    // until written, and the pointers/count reset is what empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (op == OP_PUSH) begin
            mem[wr_ptr] <= dat_i;
        end
    end

    // Pointers, occupancy flags, read data and response registers all
    // commit together on the accept edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            dat_o    <= '0;
            ack_q    <= 1'b0;
            refuse_q <= 1'b0;
        end else begin
            ack_q    <= (op == OP_PUSH) || (op == OP_POP);
            refuse_q <= (op == OP_REFUSE);
            case (op)
                OP_PUSH: begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    count_q <= count_q + CW'(1);
                    empty_q <= 1'b0;
                    full_q  <= (count_q == CW'(DEPTH - 1));
                end
                OP_POP: begin
                    dat_o   <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                    count_q <= count_q - CW'(1);
                    full_q  <= 1'b0;
                    empty_q <= (count_q == CW'(1));
                end
                default: begin
                end
            endcase
        end
    end

    assign ack_o   = ack_q;
    assign count_o = count_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

`ifdef WB_FIFO_RTY_EN
    // Refusals are reported as retry; the error line stays quiet.
    assign rty_o = refuse_q;
    assign err_o = 1'b0;
`else
    // Refusals are reported as error; the retry line stays quiet.
    assign err_o = refuse_q;
    assign rty_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_fifo_device.sv
// tb_wb_fifo_device
//   Self-checking bench for wb_fifo_device (DAT_WIDTH=8, DEPTH=16).
//   Table vectors, hand-written corner sequences and a randomized run
//   compared against a queue-based reference model.
module tb_wb_fifo_device;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_RTY  = 3;
    localparam int K_BAD  = 4;
`ifdef WB_FIFO_RTY_EN
    localparam int K_REF  = K_RTY;
`else
    localparam int K_REF  = K_ERR;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          ack;
    logic          err;
    logic          rty;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int n_checks = 0;
    int n_pass   = 0;

    wb_fifo_device #(
        .DAT_WIDTH (DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .cyc_i   (cyc),
        .stb_i   (stb),
        .we_i    (we),
        .dat_i   (din),
        .dat_o   (dout),
        .ack_o   (ack),
        .err_o   (err),
        .rty_o   (rty),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [DW-1:0] din;
        int            kind;
        logic [DW-1:0] dat;
        int            cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int resp_kind();
        int k;
        k = K_NONE;
        if (ack && !err && !rty) k = K_ACK;
        else if (!ack && err && !rty) k = K_ERR;
        else if (!ack && !err && rty) k = K_RTY;
        else if (ack || err || rty) k = K_BAD;
        return k;
    endfunction

    // Called at posedge+1 with no response pending. Returns after the
    // response cycle has ended (again at posedge+1).
    task automatic xfer(input logic w, input logic [DW-1:0] d,
                        output int kind, output int lat, output logic single);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = w;
        din  = d;
        kind = K_NONE;
        lat  = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (ack || err || rty) begin
                kind = resp_kind();
                lat  = c;
                break;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        single = !(ack || err || rty);
    endtask

    task automatic run_op(input string name, input logic w, input logic [DW-1:0] d,
                          input int exp_kind);
        int   kind;
        int   lat;
        logic single;
        xfer(w, d, kind, lat, single);
        check({name, " resp"}, kind, exp_kind);
        check({name, " latency"}, lat, 1);
        check({name, " one-cycle pulse"}, single, 1'b1);
    endtask

    task automatic check_state(input string name, input logic [DW-1:0] exp_dat, input int exp_cnt);
        check({name, " dat_o"}, dout, exp_dat);
        check({name, " count_o"}, count, exp_cnt);
        check({name, " full_o"}, full, exp_cnt == DEPTH);
        check({name, " empty_o"}, empty, exp_cnt == 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   kind;
        int   edges;
        int   n_ack;
        int   n_resp;
        logic gap_ok;
        logic [DW-1:0] mq[$];
        logic [DW-1:0] mlast;
        logic [DW-1:0] rd;
        logic          w;
        logic [DW-1:0] d;
        int            ek;
        int            bias;

        vecs[0] = '{1'b1, 8'hA5, K_ACK, 8'h00, 1};
        vecs[1] = '{1'b0, 8'h00, K_ACK, 8'hA5, 0};
        vecs[2] = '{1'b0, 8'h00, K_REF, 8'hA5, 0};
        vecs[3] = '{1'b1, 8'h3C, K_ACK, 8'hA5, 1};
        vecs[4] = '{1'b1, 8'h5A, K_ACK, 8'hA5, 2};
        vecs[5] = '{1'b0, 8'h00, K_ACK, 8'h3C, 1};
        vecs[6] = '{1'b0, 8'h00, K_ACK, 8'h5A, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset ack", ack, 1'b0);
        check("reset err", err, 1'b0);
        check("reset rty", rty, 1'b0);
        check_state("reset", 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven single transfers, including one underflow
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].din, vecs[i].kind);
            check_state($sformatf("vec%0d", i), vecs[i].dat, vecs[i].cnt);
        end

        // Fill back-to-back with stb held, then overflow
        cyc    = 1'b1;
        stb    = 1'b1;
        we     = 1'b1;
        din    = 8'h00;
        n_ack  = 0;
        edges  = 0;
        gap_ok = 1'b1;
        for (int e = 0; e < 100 && n_ack < DEPTH; e++) begin
            @(posedge clk);
            #1;
            edges++;
            if (ack) begin
                if (err || rty) gap_ok = 1'b0;
                if (edges != ((n_ack == 0) ? 1 : 2)) gap_ok = 1'b0;
                n_ack++;
                edges = 0;
                din   = DW'(n_ack);
            end else if (err || rty) begin
                gap_ok = 1'b0;
            end
        end
        check("fill ack count", n_ack, DEPTH);
        check("fill 1-per-2 rhythm", gap_ok, 1'b1);
        check("fill full_o", full, 1'b1);
        check("fill count_o", count, DEPTH);
        kind  = K_NONE;
        edges = 0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (ack || err || rty) begin
                kind  = resp_kind();
                edges = e;
                break;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        check("overflow resp", kind, K_REF);
        check("overflow back-to-back", edges, 2);
        @(posedge clk);
        #1;
        check_state("overflow", 8'h5A, DEPTH);

        // Drain in order, then underflow
        for (int i = 0; i < DEPTH; i++) begin
            run_op($sformatf("drain%0d", i), 1'b0, 8'h00, K_ACK);
            check_state($sformatf("drain%0d", i), DW'(i), DEPTH - 1 - i);
        end
        run_op("underflow", 1'b0, 8'h00, K_REF);
        check_state("underflow", 8'h0F, 0);

        // Wrap-around: offset the pointers by 10, then a full pass
        for (int i = 0; i < 10; i++) run_op($sformatf("wrap pre-w%0d", i), 1'b1, DW'(8'h40 + i), K_ACK);
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("wrap pre-r%0d", i), 1'b0, 8'h00, K_ACK);
            check($sformatf("wrap pre-r%0d dat_o", i), dout, DW'(8'h40 + i));
        end
        for (int i = 0; i < DEPTH; i++) run_op($sformatf("wrap w%0d", i), 1'b1, DW'(8'h20 + i), K_ACK);
        check("wrap full_o", full, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            run_op($sformatf("wrap r%0d", i), 1'b0, 8'h00, K_ACK);
            check($sformatf("wrap r%0d dat_o", i), dout, DW'(8'h20 + i));
        end
        check_state("wrap end", 8'h2F, 0);

        // cyc_i dropped in the response cycle while stb_i stays high
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        din = 8'h99;
        @(posedge clk);
        #1;
        check("cycdrop ack", ack, 1'b1);
        cyc    = 1'b0;
        n_resp = 0;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            if (ack || err || rty) n_resp++;
        end
        stb = 1'b0;
        we  = 1'b0;
        check("cycdrop extra responses", n_resp, 0);
        check("cycdrop count_o", count, 1);
        run_op("cycdrop readback", 1'b0, 8'h00, K_ACK);
        check_state("cycdrop readback", 8'h99, 0);

        // Asynchronous reset in the middle of a response cycle
        run_op("areset prefill", 1'b1, 8'h11, K_ACK);
        cyc = 1'b1;
        stb = 1'b1;
        we  = 1'b1;
        din = 8'h77;
        @(posedge clk);
        #1;
        check("areset pending ack", ack, 1'b1);
        check("areset pre count_o", count, 2);
        #2;
        rst = 1'b1;
        #1;
        check("areset ack", ack, 1'b0);
        check("areset err", err, 1'b0);
        check("areset rty", rty, 1'b0);
        check_state("areset", 8'h00, 0);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("areset discarded", 1'b0, 8'h00, K_REF);

        // Randomized run against a queue model, starting from reset
        do_reset();
        mq.delete();
        mlast = '0;
        for (int i = 0; i < 300; i++) begin
            bias = (((i / 40) % 2) == 0) ? 85 : 15;
            w    = ($urandom_range(0, 99) < bias);
            d    = DW'($urandom_range(0, 255));
            if (w) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(d);
                    ek = K_ACK;
                end else begin
                    ek = K_REF;
                end
            end else begin
                if (mq.size() > 0) begin
                    rd    = mq.pop_front();
                    mlast = rd;
                    ek    = K_ACK;
                end else begin
                    ek = K_REF;
                end
            end
            run_op($sformatf("rand%0d", i), w, d, ek);
            check_state($sformatf("rand%0d", i), mlast, mq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
